// File: rtl/psa_arbiter.sv
// Round-robin front end for the shared nibble-lane saturating adder.
// Two requesters share the adder. Each accepted op takes three cycles: grant, execute, then result valid.
module psa_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic [WIDTH-1:0] psa_a,
    output logic [WIDTH-1:0] psa_b,
    input  logic [WIDTH-1:0] psa_sum,
    input  logic             psa_err,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    logic   rr_r;
    logic   grant_s;
    logic   win_s;

    // Arbitration: on a tie, the requester that was not granted last wins
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (req0 && req1) begin
            grant_s = 1'b1;
            win_s   = ~rr_r;
        end else if (req0) begin
            grant_s = 1'b1;
            win_s   = 1'b0;
        end else if (req1) begin
            grant_s = 1'b1;
            win_s   = 1'b1;
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // Sequencer. psa_a/psa_b double as the operand registers and are zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_r      <= 1'b1;
            psa_a     <= '0;
            psa_b     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_sum   <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        psa_a   <= win_s ? a1 : a0;
                        psa_b   <= win_s ? b1 : b0;
                        gnt0    <= ~win_s;
                        gnt1    <= win_s;
                        res_id  <= win_s;
                        rr_r    <= win_s;
                        busy    <= 1'b1;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    res_sum   <= psa_sum;
                    res_err   <= psa_err;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    res_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    psa_a     <= '0;
                    psa_b     <= '0;
                    state_r   <= IDLE;
                end
                default: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    psa_a     <= '0;
                    psa_b     <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psa_arbiter.sv
// Bench for psa_arbiter: behavioural adder plus a timeline model of grants and results.
module tb_psa_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1;
    logic [W-1:0] psa_a, psa_b, psa_sum;
    logic         psa_err;
    logic         busy, res_valid, res_id, res_err;
    logic [W-1:0] res_sum;

    int n_err = 0;
    int n_chk = 0;

    // Model state: cycle index, last grant edge, last winner, captured op, held result
    int           cyc = 0;
    int           t_g = -1000;
    int           last_m = 1;
    int           id_m = 0;
    logic [W-1:0] opa_m = '0, opb_m = '0, rs_m = '0;
    logic         re_m = 1'b0;
    int           c0, c1;

    psa_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .psa_a(psa_a), .psa_b(psa_b), .psa_sum(psa_sum), .psa_err(psa_err),
        .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res_sum(res_sum), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Signed 4-bit lanes saturating to 0x7/0x8; error if any lane saturated
    function automatic logic [W:0] add_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         e;
        int           x;
        s = '0;
        e = 1'b0;
        for (int l = 0; l < W / 4; l++) begin
            x = $signed(a[4*l +: 4]) + $signed(b[4*l +: 4]);
            if (x > 7) begin
                x = 7;
                e = 1'b1;
            end else if (x < -8) begin
                x = -8;
                e = 1'b1;
            end
            s[4*l +: 4] = x[3:0];
        end
        return {e, s};
    endfunction

    always_comb {psa_err, psa_sum} = add_model(psa_a, psa_b);

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t_g    = -1000;
        last_m = 1;
        id_m   = 0;
        opa_m  = '0;
        opb_m  = '0;
        rs_m   = '0;
        re_m   = 1'b0;
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare every output
    task automatic step();
        logic bz;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (cyc >= t_g + 3 && (req0 || req1)) begin
                id_m   = (req0 && req1) ? (last_m == 1 ? 0 : 1) : (req0 ? 0 : 1);
                last_m = id_m;
                t_g    = cyc;
                opa_m  = (id_m == 1) ? a1 : a0;
                opb_m  = (id_m == 1) ? b1 : b0;
            end
            if (cyc == t_g + 1) {re_m, rs_m} = add_model(opa_m, opb_m);
        end
        #1;
        bz = (cyc == t_g) || (cyc == t_g + 1);
        chk("gnt0",      W'(gnt0),      W'((cyc == t_g) && (id_m == 0)));
        chk("gnt1",      W'(gnt1),      W'((cyc == t_g) && (id_m == 1)));
        chk("busy",      W'(busy),      W'(bz));
        chk("res_valid", W'(res_valid), W'(cyc == t_g + 1));
        chk("res_id",    W'(res_id),    W'(id_m));
        chk("res_sum",   res_sum,       rs_m);
        chk("res_err",   W'(res_err),   W'(re_m));
        chk("psa_a",     psa_a,         bz ? opa_m : '0);
        chk("psa_b",     psa_b,         bz ? opb_m : '0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        step();
        rst = 1'b0;

        // Basic op from requester 0; operands disturbed right after the grant
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        step();
        chk("first_psa_a", psa_a, 16'h1234);
        req0 = 1'b0; a0 = 16'hFFFF;
        step();
        chk("first_sum", res_sum, 16'h2345);
        step();

        // Saturation pass-through on requester 1
        req1 = 1'b1; a1 = 16'h7000; b1 = 16'h1000;
        step();
        req1 = 1'b0;
        step();
        chk("sat_pos", res_sum, 16'h7000);
        step();
        req1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000;
        step();
        req1 = 1'b0;
        step();
        chk("sat_neg", res_sum, 16'h8000);
        chk("sat_neg_err", W'(res_err), 16'h0001);
        step();

        // Operand isolation, and a request arriving while busy waits for IDLE
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001;
        step();
        req0 = 1'b0; a0 = 16'hFFFF; req1 = 1'b1; a1 = 16'h0123; b1 = 16'h0321;
        step();
        chk("iso_sum", res_sum, 16'h0002);
        step();
        chk("busy_req_wait", W'(gnt1), 16'h0000);
        step();
        chk("busy_req_gnt", W'(gnt1), 16'h0001);
        req1 = 1'b0;
        step();
        step();

        // Continuous contention: grants alternate starting with requester 0
        req0 = 1'b1; req1 = 1'b1; a0 = 16'h0101; b0 = 16'h0202; a1 = 16'h3030; b1 = 16'h4040;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) chk("cont_first", W'(gnt0), 16'h0001);
            if (gnt0 === 1'b1) c0++;
            if (gnt1 === 1'b1) c1++;
        end
        chk("cont_gnt0_cnt", W'(c0), 16'd2);
        chk("cont_gnt1_cnt", W'(c1), 16'd2);
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();

        // Async reset while executing; the op is dropped
        req0 = 1'b1; a0 = 16'h2222; b0 = 16'h3333;
        step();
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", W'(busy), 16'h0000);
        chk("rst_gnt0", W'(gnt0), 16'h0000);
        chk("rst_valid", W'(res_valid), 16'h0000);
        chk("rst_psa_a", psa_a, 16'h0000);
        model_reset();
        step();
        rst = 1'b0; req1 = 1'b1;
        step();
        chk("post_rst_tie", W'(gnt0), 16'h0001);
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();

        // Idle quiescence
        for (int i = 0; i < 10; i++) step();

        // Random traffic: each requester holds until granted, may re-request with new operands
        for (int i = 0; i < 400; i++) begin
            if (req0 && gnt0) begin
                req0 = ($urandom_range(1) == 1);
                a0 = W'($urandom); b0 = W'($urandom);
            end else if (!req0 && $urandom_range(9) < 4) begin
                req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
            end
            if (req1 && gnt1) begin
                req1 = ($urandom_range(1) == 1);
                a1 = W'($urandom); b1 = W'($urandom);
            end else if (!req1 && $urandom_range(9) < 4) begin
                req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
